// File: rtl/sopc_mem_arb_pkg.sv
// Shared defines for the SOPC memory arbiter: bus widths, FSM state encoding
// and requester port identifiers.
package sopc_mem_arb_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_id_e;

endpackage

// File: rtl/sopc_mem_bank.sv
// Single-port DEPTH x DATA_W storage with per-byte write enables and a
// registered read port; contents are deliberately not reset.
module sopc_mem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096
) (
  input  logic                     clk,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [DATA_W/8-1:0]      i_sel,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // An enabled cycle either merges the selected bytes or loads the read register.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
          if (i_sel[b]) begin
            r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sopc_mem_arb.sv
// Two-port (instruction fetch / data) arbiter in front of one internal memory
// bank; one transaction in flight, data preferred unless fetch is starving.
module sopc_mem_arb
  import sopc_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = BUS_ADDR_W,
  parameter int DATA_W     = BUS_DATA_W,
  parameter int DEPTH      = 4096,
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_err_o,
  output logic                busy_o
);

  localparam int              SEL_W      = DATA_W / 8;
  localparam int              IDX_W      = $clog2(DEPTH);
  localparam int              SC_W       = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_SAT = SC_W'(STARVE_MAX);
  localparam logic [2:0]      WAIT_INIT  = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;
  localparam bit              NO_WAIT    = (LATENCY == 0);

  arb_state_e        r_state;
  logic [SC_W-1:0]   r_starve;
  logic [2:0]        r_wait_cnt;
  port_id_e          r_port;
  logic              r_we;
  logic              r_oor;
  logic [IDX_W-1:0]  r_idx;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_wdata;
  logic              r_if_rvalid;
  logic              r_d_rvalid;
  logic              r_d_err;
  logic              r_busy;

  logic              w_idle;
  logic              w_d_gnt;
  logic              w_if_gnt;
  logic              w_any_gnt;
  logic [ADDR_W-1:0] w_g_addr;
  port_id_e          w_acc_port;
  logic              w_acc_we;
  logic              w_acc_oor;
  logic [IDX_W-1:0]  w_acc_idx;
  logic [SEL_W-1:0]  w_acc_sel;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_to_resp;
  logic              w_bank_en;
  logic [DATA_W-1:0] w_bank_rdata;
  logic              w_unused;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_d_gnt   = w_idle & d_req_i & ~(if_req_i & (r_starve == STARVE_SAT));
  assign w_if_gnt  = w_idle & if_req_i & ~w_d_gnt;
  assign w_any_gnt = w_d_gnt | w_if_gnt;
  assign w_g_addr  = w_d_gnt ? d_addr_i : if_addr_i;

  // Without wait states the bank is accessed on the grant edge, before r_* load.
  assign w_acc_port  = w_idle ? (w_d_gnt ? PORT_D : PORT_IF) : r_port;
  assign w_acc_we    = w_idle ? (w_d_gnt & d_we_i) : r_we;
  assign w_acc_oor   = w_idle ? (|w_g_addr[ADDR_W-1:IDX_W+2]) : r_oor;
  assign w_acc_idx   = w_idle ? w_g_addr[IDX_W+1:2] : r_idx;
  assign w_acc_sel   = w_idle ? d_sel_i : r_sel;
  assign w_acc_wdata = w_idle ? d_wdata_i : r_wdata;

  assign w_to_resp = (w_idle & w_any_gnt & NO_WAIT) |
                     ((r_state == ST_WAIT) & (r_wait_cnt == 3'd0));
  assign w_bank_en = w_to_resp & ~w_acc_oor & ~rst;

  sopc_mem_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk     (clk),
    .i_en    (w_bank_en),
    .i_we    (w_acc_we),
    .i_sel   (w_acc_sel),
    .i_idx   (w_acc_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_bank_rdata)
  );

  // Arbiter FSM, starvation counter, request capture and registered responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_starve    <= {SC_W{1'b0}};
      r_wait_cnt  <= 3'd0;
      r_port      <= PORT_IF;
      r_we        <= 1'b0;
      r_oor       <= 1'b0;
      r_idx       <= {IDX_W{1'b0}};
      r_sel       <= {SEL_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_err     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_if_gnt || !if_req_i) begin
        r_starve <= {SC_W{1'b0}};
      end else if (w_d_gnt && (r_starve != STARVE_SAT)) begin
        r_starve <= r_starve + 1'b1;
      end
      r_if_rvalid <= w_to_resp & (w_acc_port == PORT_IF);
      r_d_rvalid  <= w_to_resp & (w_acc_port == PORT_D);
      r_d_err     <= w_to_resp & (w_acc_port == PORT_D) & w_acc_oor;
      if (w_any_gnt) begin
        r_port  <= w_acc_port;
        r_we    <= w_acc_we;
        r_oor   <= w_acc_oor;
        r_idx   <= w_acc_idx;
        r_sel   <= w_acc_sel;
        r_wdata <= w_acc_wdata;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any_gnt) begin
            r_state    <= NO_WAIT ? ST_RESP : ST_WAIT;
            r_wait_cnt <= WAIT_INIT;
            r_busy     <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == 3'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt_o    = w_if_gnt;
  assign d_gnt_o     = w_d_gnt;
  assign if_rvalid_o = r_if_rvalid;
  assign d_rvalid_o  = r_d_rvalid;
  assign d_err_o     = r_d_err;
  assign busy_o      = r_busy;
  assign if_rdata_o  = (r_if_rvalid & ~r_oor) ? w_bank_rdata : {DATA_W{1'b0}};
  assign d_rdata_o   = (r_d_rvalid & ~r_we & ~r_oor) ? w_bank_rdata : {DATA_W{1'b0}};

  assign w_unused = ^{if_addr_i[1:0], d_addr_i[1:0]};

endmodule

// File: tb/tb_sopc_mem_arb.sv
// Bench for sopc_mem_arb: instance 0 with LATENCY=2, instance 1 with LATENCY=0,
// both checked each cycle against a transaction-level model plus literal checks.
module tb_sopc_mem_arb;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req [2];
  logic        d_req  [2];
  logic        d_we   [2];
  logic [31:0] if_addr[2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata[2];
  logic [3:0]  d_sel  [2];
  logic        if_gnt [2];
  logic        if_rvalid[2];
  logic [31:0] if_rdata[2];
  logic        d_gnt  [2];
  logic        d_rvalid[2];
  logic [31:0] d_rdata[2];
  logic        d_err  [2];
  logic        busy   [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sopc_mem_arb #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(4096),
      .LATENCY((g == 0) ? 2 : 0), .STARVE_MAX(SMAX)
    ) u_dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req[g]), .if_addr_i(if_addr[g]), .if_gnt_o(if_gnt[g]),
      .if_rvalid_o(if_rvalid[g]), .if_rdata_o(if_rdata[g]),
      .d_req_i(d_req[g]), .d_we_i(d_we[g]), .d_addr_i(d_addr[g]), .d_sel_i(d_sel[g]),
      .d_wdata_i(d_wdata[g]), .d_gnt_o(d_gnt[g]), .d_rvalid_o(d_rvalid[g]),
      .d_rdata_o(d_rdata[g]), .d_err_o(d_err[g]), .busy_o(busy[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model state, one set per instance
  logic [31:0] mem_m [2][4096];
  bit          known [2][4096];
  int          free_at[2], starve[2], due[2], gcyc[2], p_idx[2];
  bit          pend[2], p_dport[2], p_we[2], p_oor[2];
  logic [3:0]  p_sel[2];
  logic [31:0] p_wdata[2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic model_step(input int k);
    bit          due_now, eg_d, eg_if, chk_data, exp_busy;
    logic [31:0] exp_data, a;
    due_now  = pend[k] && (due[k] == cyc);
    exp_data = 32'h0;
    chk_data = 1'b1;
    if (due_now && p_dport[k] && p_we[k] && !p_oor[k]) begin
      for (int b = 0; b < 4; b++)
        if (p_sel[k][b]) mem_m[k][p_idx[k]][b*8 +: 8] = p_wdata[k][b*8 +: 8];
      if (p_sel[k] == 4'hF) known[k][p_idx[k]] = 1'b1;
    end else if (due_now && !p_we[k] && !p_oor[k]) begin
      exp_data = mem_m[k][p_idx[k]];
      chk_data = known[k][p_idx[k]];
    end
    exp_busy = pend[k] && (cyc > gcyc[k]) && (cyc <= due[k]);
    eg_d  = (cyc >= free_at[k]) && d_req[k] && !(if_req[k] && (starve[k] == SMAX));
    eg_if = (cyc >= free_at[k]) && if_req[k] && !eg_d;

    check($sformatf("d%0d.if_gnt", k), 32'(if_gnt[k]), 32'(eg_if));
    check($sformatf("d%0d.d_gnt", k), 32'(d_gnt[k]), 32'(eg_d));
    check($sformatf("d%0d.if_rvalid", k), 32'(if_rvalid[k]), 32'(due_now && !p_dport[k]));
    check($sformatf("d%0d.d_rvalid", k), 32'(d_rvalid[k]), 32'(due_now && p_dport[k]));
    check($sformatf("d%0d.busy", k), 32'(busy[k]), 32'(exp_busy));
    if (due_now && !p_dport[k] && chk_data)
      check($sformatf("d%0d.if_rdata", k), if_rdata[k], exp_data);
    if (due_now && p_dport[k]) begin
      check($sformatf("d%0d.d_err", k), 32'(d_err[k]), 32'(p_oor[k]));
      if (chk_data) check($sformatf("d%0d.d_rdata", k), d_rdata[k], exp_data);
    end

    if (due_now) pend[k] = 1'b0;
    if (eg_d || eg_if) begin
      a          = eg_d ? d_addr[k] : if_addr[k];
      pend[k]    = 1'b1;
      gcyc[k]    = cyc;
      due[k]     = cyc + lat_of(k) + 1;
      free_at[k] = due[k] + 1;
      p_dport[k] = eg_d;
      p_we[k]    = eg_d && d_we[k];
      p_idx[k]   = int'(a[13:2]);
      p_oor[k]   = |a[31:14];
      p_sel[k]   = d_sel[k];
      p_wdata[k] = d_wdata[k];
    end
    if (eg_if || !if_req[k]) starve[k] = 0;
    else if (eg_d && (starve[k] < SMAX)) starve[k] = starve[k] + 1;
    if (rst) begin
      pend[k]    = 1'b0;
      starve[k]  = 0;
      free_at[k] = cyc + 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: armed once a reset edge has been applied
  initial begin
    bit armed, prev_rst;
    armed = 1'b0;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_rst) armed = 1'b1;
      if (armed) for (int k = 0; k < 2; k++) model_step(k);
      prev_rst = rst;
    end
  end

  task automatic d_op(input int k, input logic we, input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                      output logic err);
    bit got, rv;
    @(posedge clk); #1;
    d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_sel[k] = sel; d_wdata[k] = wdata;
    got = 1'b0;
    for (int t = 0; t < 40; t++) if (!got) begin @(negedge clk); got = d_gnt[k]; end
    check($sformatf("d%0d.gnt_seen", k), 32'(got), 32'h1);
    @(posedge clk); #1;
    d_req[k] = 1'b0;
    rv = 1'b0; lat = 0; rdata = 32'h0; err = 1'b0;
    for (int t = 0; t < 20; t++) if (!rv) begin
      @(negedge clk);
      lat++;
      rv = d_rvalid[k]; rdata = d_rdata[k]; err = d_err[k];
    end
    check($sformatf("d%0d.rvalid_seen", k), 32'(rv), 32'h1);
  endtask

  initial begin
    int          lat, ng, adj;
    logic [31:0] rd;
    logic        err;
    bit          got, seen, prev;
    logic [9:0]  seq;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0; if_addr[k] = 32'h0;
      d_addr[k] = 32'h0; d_wdata[k] = 32'h0; d_sel[k] = 4'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy[0]), 32'h0);
    check("reset_d_rvalid", 32'(d_rvalid[0]), 32'h0);
    check("reset_d_rdata", d_rdata[1], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LATENCY=2 full write then read
    d_op(0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, lat, rd, err);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_ack_rdata", rd, 32'h0);
    d_op(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, lat, rd, err);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_data", rd, 32'hDEADBEEF);

    // Partial byte write
    d_op(0, 1'b1, 32'h0000_0010, 4'h3, 32'h1234_5678, lat, rd, err);
    d_op(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, lat, rd, err);
    check("partial_rd", rd, 32'hDEAD5678);

    // Out of range access must not alias onto word 0
    d_op(0, 1'b1, 32'h0000_0000, 4'hF, 32'h0BADF00D, lat, rd, err);
    d_op(0, 1'b0, 32'h0000_4000, 4'h0, 32'h0, lat, rd, err);
    check("oor_rd_err", 32'(err), 32'h1);
    check("oor_rd_data", rd, 32'h0);
    d_op(0, 1'b1, 32'h0000_4000, 4'hF, 32'hFFFF_FFFF, lat, rd, err);
    check("oor_wr_err", 32'(err), 32'h1);
    d_op(0, 1'b0, 32'h0000_0000, 4'h0, 32'h0, lat, rd, err);
    check("oor_word0_kept", rd, 32'h0BADF00D);

    // Reset while a write sits in WAIT
    @(posedge clk); #1;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h10; d_sel[0] = 4'hF; d_wdata[0] = 32'h1111_1111;
    got = 1'b0;
    for (int t = 0; t < 20; t++) if (!got) begin @(negedge clk); got = d_gnt[0]; end
    check("rstwait_gnt", 32'(got), 32'h1);
    @(posedge clk); #1;
    d_req[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstwait_busy_in_wait", 32'(busy[0]), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstwait_busy_after", 32'(busy[0]), 32'h0);
    seen = d_rvalid[0];
    for (int t = 0; t < 4; t++) begin @(negedge clk); seen = seen | d_rvalid[0]; end
    check("rstwait_no_rvalid", 32'(seen), 32'h0);
    d_op(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, lat, rd, err);
    check("rstwait_word_kept", rd, 32'hDEAD5678);

    // Both requesters held high: four data grants then one fetch grant
    @(posedge clk); #1;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h10; if_req[0] = 1'b1; if_addr[0] = 32'h10;
    seq = 10'h0; ng = 0;
    for (int t = 0; t < 45; t++) begin
      @(negedge clk);
      if (d_gnt[0] || if_gnt[0]) begin
        if (ng < 10) seq[9 - ng] = d_gnt[0];
        ng++;
      end
    end
    check("starve_pattern", 32'(seq), 32'h3DE);
    check("starve_grant_count", 32'(ng), 32'd12);
    @(posedge clk); #1;
    d_req[0] = 1'b0; if_req[0] = 1'b0;
    repeat (8) @(posedge clk);

    // LATENCY=0 back-to-back fetches
    d_op(1, 1'b1, 32'h0000_0020, 4'hF, 32'hCAFEF00D, lat, rd, err);
    check("l0_wr_latency", 32'(lat), 32'd1);
    @(posedge clk); #1;
    if_req[1] = 1'b1; if_addr[1] = 32'h0000_0022;
    ng = 0; adj = 0; prev = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (prev) begin
        check("l0_fetch_rvalid", 32'(if_rvalid[1]), 32'h1);
        check("l0_fetch_rdata", if_rdata[1], 32'hCAFEF00D);
      end
      if (prev && if_gnt[1]) adj++;
      if (if_gnt[1]) ng++;
      prev = if_gnt[1];
    end
    check("l0_fetch_grants", 32'(ng), 32'd6);
    check("l0_no_adjacent_gnt", 32'(adj), 32'd0);
    @(posedge clk); #1;
    if_req[1] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/sopc_mem_arb.md
SOPC_MEM_ARB -- requirements
Module: sopc_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 4096, words of internal storage; power of two.
REQ-004 SHALL have parameter LATENCY, default 1, wait states between grant and response, range 0..7.
REQ-005 SHALL have parameter STARVE_MAX, default 4, consecutive data grants allowed while fetch waits.
REQ-006 SHALL have clk  input  1  sole clock; all logic on the rising edge.
REQ-007 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-008 SHALL have if_req_i  input  1  instruction-fetch request.
REQ-009 SHALL have if_addr_i  input  ADDR_W  fetch byte address.
REQ-010 SHALL have if_gnt_o  output  1  fetch request accepted this cycle.
REQ-011 SHALL have if_rvalid_o  output  1  fetch response valid, one cycle.
REQ-012 SHALL have if_rdata_o  output  DATA_W  fetch read data.
REQ-013 SHALL have d_req_i  input  1  data request.
REQ-014 SHALL have d_we_i  input  1  1 = write, 0 = read.
REQ-015 SHALL have d_addr_i  input  ADDR_W  data byte address.
REQ-016 SHALL have d_sel_i  input  DATA_W/8  byte enables for writes.
REQ-017 SHALL have d_wdata_i  input  DATA_W  write data.
REQ-018 SHALL have d_gnt_o  output  1  data request accepted this cycle.
REQ-019 SHALL have d_rvalid_o  output  1  data response (read data or write ack), one cycle.
REQ-020 SHALL have d_rdata_o  output  DATA_W  data read data; 0 on write ack.
REQ-021 SHALL have d_err_o  output  1  out-of-range access, qualified by d_rvalid_o.
REQ-022 SHALL have busy_o  output  1  transaction in flight.

Function
REQ-023 SHALL run FSM IDLE -> WAIT -> RESP -> IDLE; WAIT skipped when LATENCY=0.
REQ-024 SHALL grant only in IDLE, combinationally from current requests; at most one gnt per cycle; one transaction outstanding.
REQ-025 SHALL register granted address, we, sel, wdata and port id in the grant cycle; requesters hold inputs until gnt.
REQ-026 SHALL give data priority over fetch, except fetch wins when starve counter equals STARVE_MAX.
REQ-027 SHALL increment starve counter on each data grant while if_req_i high, clear it on any fetch grant or fetch idle; saturate at STARVE_MAX.
REQ-028 SHALL hold WAIT for exactly LATENCY cycles, so rvalid asserts exactly LATENCY+1 cycles after gnt.
REQ-029 SHALL, in RESP, assert only the granted port's rvalid for one cycle, then return to IDLE; next grant no earlier than the following cycle.
REQ-030 SHALL form word index from addr[log2(DEPTH)+1:2]; addr[1:0] ignored.
REQ-031 SHALL treat addr[ADDR_W-1:2] >= DEPTH as out of range: no write, rdata 0, d_err_o=1 for data; fetch returns 0.
REQ-032 SHALL perform writes at RESP entry, updating only bytes with d_sel_i set; sel=0 is a legal no-op acked normally.
REQ-033 SHALL return read data sampled in RESP, reflecting all earlier completed writes.
REQ-034 SHALL assert busy_o in WAIT and RESP.

Reset
REQ-035 SHALL on rst: FSM IDLE, starve counter 0, all gnt/rvalid/err/busy 0, rdata outputs 0.
REQ-036 SHALL abandon an in-flight transaction on rst with no rvalid and no write performed; storage contents not cleared.

Structure
REQ-037 SHALL place FSM state encoding and port-id constants in the shared defines package alongside existing bus-width macros.
REQ-038 SHALL implement storage as sub-module sopc_mem_bank (single-port, byte-write-enable, DEPTH x DATA_W).

Verification
REQ-039 SHALL cover: LATENCY=2, d write 0x0000_0010 data 0xDEADBEEF sel 0xF, then read -> d_rvalid_o 3 cycles after each gnt, rdata 0xDEADBEEF.
REQ-040 SHALL cover: write sel 0x3 data 0x1234_5678 over 0xDEADBEEF -> read 0xDEAD5678.
REQ-041 SHALL cover: if_req_i and d_req_i held high continuously, STARVE_MAX=4 -> 4 data grants then 1 fetch grant, repeating.
REQ-042 SHALL cover: DEPTH=4096, d read addr 0x0000_4000 -> d_rvalid_o with d_err_o=1, rdata 0; write there leaves word 0 unchanged.
REQ-043 SHALL cover: rst asserted during WAIT of a write -> no rvalid, target word keeps old value, busy_o 0 next cycle.
REQ-044 SHALL cover: LATENCY=0 back-to-back fetches -> gnt every 2nd cycle, rvalid 1 cycle after each gnt.
